test_mm_block_mover: RTL and testbench
======================================

# test_mm_block_mover

Avalon-MM master that copies a block of 32-bit words from one region of the on-chip memory to another through the memory's s1 slave port. Sits beside the processor in the test system. A simple command interface lets software or a sequencer launch board-state copies, such as snapshotting a sudoku grid before a speculative solve step, without tying up the CPU. It drives the single-port RAM word by word: read, wait the fixed read latency, write, then advance.

## Interface
Parameters:
- ADDR_W, 14, word-address width of the master port and command fields.
- DEPTH, 10024, number of valid words in the target memory; used for range checking.
- READ_LATENCY, 1, cycles from accepted read to valid m_readdata; legal range 1..3.

Ports:
- clk  in  1  system clock; all logic is in this single clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address.
- dst_addr  in  ADDR_W  first destination word address.
- len  in  ADDR_W  number of words to copy.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a copy completes.
- error  out  1  one-cycle pulse when a start is rejected for being out of range.
- checksum  out  32  running sum of copied words (see Configuration).
- m_address  out  ADDR_W  word address to the memory.
- m_read  out  1  read request.
- m_write  out  1  write request.
- m_byteenable  out  4  constant 4'hF whenever m_read or m_write is high, else 4'h0.
- m_writedata  out  32  write data.
- m_readdata  in  32  read data from the memory.
- m_waitrequest  in  1  slave stall; the request is held unchanged while it is high.

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE
  - On start, the command is latched: src to sptr, dst to dptr, len to remaining.
  - Range check: if src+len > DEPTH or dst+len > DEPTH (computed at ADDR_W+1 bits), pulse error and stay in IDLE. No bus activity occurs.
  - Else if len==0, go to DONE.
  - Else go to READ.
- READ
  - m_read=1 and m_address=sptr.
  - When m_waitrequest=0 the read is accepted: load the latency counter with READ_LATENCY and go to WAIT.
- WAIT
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 0, capture m_readdata into the data register and go to WRITE.
- WRITE
  - m_write=1, m_address=dptr, m_writedata=data register.
  - On acceptance (m_waitrequest=0): increment sptr and dptr, decrement remaining.
  - If remaining was 1, go to DONE; otherwise go to READ.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored; command inputs are not re-sampled.
- Copies always run in ascending order. For overlapping regions with dst>src, the result is undefined; this is the software's responsibility.
- m_read and m_write are never high in the same cycle.
- Reset mid-copy: all state returns to IDLE immediately (asynchronously); m_read, m_write, busy, done and error go low. A partial copy is left in memory as-is.

## Timing
- Reset values:
  - busy, done, error, m_read, m_write = 0.
  - m_byteenable = 4'h0; m_address, m_writedata, checksum = 0.
  - State = IDLE.
- With start sampled at edge k, busy and m_read rise after edge k.
- With zero waitrequest and READ_LATENCY=L, each word takes 2+L cycles, so an N-word copy takes N*(2+L) cycles plus 1 DONE cycle.
- Each waitrequest cycle extends the corresponding READ or WRITE state by one cycle.
- len==0: busy and done are high for exactly the one cycle after the start edge.
- error pulses in the cycle after the start edge; busy stays 0.

## Configuration
- CHECKSUM_EN defined:
  - checksum clears to 0 on an accepted start (including len==0).
  - Each captured word is added modulo 2^32.
  - The value holds after done until the next accepted start.
- CHECKSUM_EN undefined: no adder or register is built; checksum is tied to 32'h0.

## Test plan
- Basic copy: preload words 0..3 = 1,2,3,4; start src=0, dst=100, len=4; L=1, no waitrequest -> words 100..103 = 1,2,3,4. done arrives 12 cycles after busy rises; checksum=10 with CHECKSUM_EN.
- Waitrequest: same copy with waitrequest high for 2 cycles on every read and write -> same memory contents, 16 extra cycles, request signals stable while stalled.
- Range error: start src=10000, dst=0, len=30 -> error pulses, busy stays 0, no m_read or m_write.
- Zero length: start len=0 -> one-cycle busy and done, no bus cycles, checksum=0.
- Reset mid-copy: assert reset during the WRITE of word 2 of a 4-word copy -> all outputs return to reset values in the same cycle. A subsequent start succeeds.
- Ignored start: pulse start during a copy with different operands -> the first copy completes unchanged and only one done pulse occurs.

Source files
------------

// File: rtl/test_mm_block_mover.sv
// test_mm_block_mover: Avalon-MM master copying a block of 32-bit words between memory regions.
// Ports: clk/reset (async, active-high); start/src_addr/dst_addr/len command inputs;
// busy/done/error status; checksum of copied words; m_* Avalon-MM master towards the RAM s1 port.
// Optional feature macro CHECKSUM_EN builds the running checksum; otherwise checksum is 0.
module test_mm_block_mover #(
    parameter int ADDR_W       = 14,
    parameter int DEPTH        = 10024,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    input  logic              m_waitrequest
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] sptr_q, sptr_d, dptr_q, dptr_d, rem_q, rem_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   src_end, dst_end;
    logic              range_bad;
    // End addresses are one bit wider so src+len cannot wrap past the check.
    assign src_end   = {1'b0, src_addr} + {1'b0, len};
    assign dst_end   = {1'b0, dst_addr} + {1'b0, len};
    assign range_bad = (src_end > DEPTH_W) || (dst_end > DEPTH_W);
    always_comb begin
        state_d = state_q;
        sptr_d  = sptr_q;
        dptr_d  = dptr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                sptr_d  = src_addr;
                dptr_d  = dst_addr;
                rem_d   = len;
                err_d   = range_bad;
                state_d = range_bad ? IDLE : (len == '0 ? DONE : READ);
            end
            READ: if (!m_waitrequest) begin
                cnt_d   = 2'(READ_LATENCY);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    data_d  = m_readdata;
                    state_d = WRITE;
                end
            end
            WRITE: if (!m_waitrequest) begin
                sptr_d  = sptr_q + ADDR_W'(1);
                dptr_d  = dptr_q + ADDR_W'(1);
                rem_d   = rem_q - ADDR_W'(1);
                state_d = (rem_q == ADDR_W'(1)) ? DONE : READ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sptr_q  <= '0;
            dptr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sptr_q  <= sptr_d;
            dptr_q  <= dptr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
`ifdef CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;
    // Cleared on an accepted start, accumulates on the same cycle the data register captures.
    always_comb begin
        checksum_d = (state_q == IDLE && start && !range_bad) ? 32'h0 :
                     (state_q == WAIT && cnt_q == 2'd1) ? checksum_q + m_readdata : checksum_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) checksum_q <= 32'h0;
        else       checksum_q <= checksum_d;
    end
    assign checksum = checksum_q;
`else
    assign checksum = 32'h0;
`endif
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign error        = err_q;
    assign m_read       = state_q == READ;
    assign m_write      = state_q == WRITE;
    assign m_address    = m_read ? sptr_q : (m_write ? dptr_q : '0);
    assign m_writedata  = m_write ? data_q : 32'h0;
    assign m_byteenable = (m_read || m_write) ? 4'hF : 4'h0;
endmodule

// File: tb/tb_test_mm_block_mover.sv
// tb_test_mm_block_mover: directed self-checking bench for test_mm_block_mover with a RAM model.
module tb_test_mm_block_mover;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] src_addr = '0, dst_addr = '0, len = '0;
    logic        busy, done, error, m_read, m_write, m_waitrequest;
    logic [31:0] checksum, m_writedata, m_readdata;
    logic [13:0] m_address;
    logic [3:0]  m_byteenable;
    logic [31:0] mem [0:16383];
    logic [31:0] rdata = '0;
    logic        stall_en = 1'b0;
    int          stall_cnt = 0;
    logic        tb_we = 1'b0;
    logic [13:0] tb_wa = '0;
    logic [31:0] tb_wd = '0;
    int total = 0, bad = 0;
    int done_cnt = 0, bus_cnt = 0, both_bad = 0, stab_bad = 0, stab_chk = 0;
    logic        pend = 1'b0;
    logic [47:0] saved;
    always #5 clk = ~clk;
    test_mm_block_mover dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .error(error), .checksum(checksum),
        .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_byteenable(m_byteenable),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
    );
    assign m_readdata    = rdata;
    assign m_waitrequest = stall_en && (m_read || m_write) && stall_cnt < 2;
    // RAM with one cycle read latency; stalls each request for two cycles when stall_en is set.
    always @(posedge clk) begin
        if (tb_we) mem[tb_wa] <= tb_wd;
        if (m_write && !m_waitrequest) mem[m_address] <= m_writedata;
        if (m_read && !m_waitrequest) rdata <= mem[m_address];
        if (!stall_en) stall_cnt <= 0;
        else if (m_read || m_write) stall_cnt <= (stall_cnt < 2) ? stall_cnt + 1 : 0;
    end
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (m_read || m_write) bus_cnt <= bus_cnt + 1;
        if (m_read && m_write) both_bad <= both_bad + 1;
        if (pend) begin
            stab_chk <= stab_chk + 1;
            if ({m_read, m_write, m_address, m_writedata} != saved) stab_bad <= stab_bad + 1;
        end
        pend  <= (m_read || m_write) && m_waitrequest;
        saved <= {m_read, m_write, m_address, m_writedata};
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic poke(input logic [13:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        tick;
        tb_we = 1'b0;
    endtask
    task automatic go(input logic [13:0] s, input logic [13:0] d, input logic [13:0] n);
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        tick;
        start = 1'b0;
    endtask
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            tick;
            cyc++;
        end
    endtask
    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {busy, done, error, m_read, m_write, m_byteenable}, 64'h0);
        check({tag, "_addr"}, m_address, 64'h0);
        check({tag, "_wdata"}, m_writedata, 64'h0);
        check({tag, "_csum"}, checksum, 64'h0);
    endtask
    initial begin
        int cyc, b0, d0, n;
        logic [31:0] exp_sum;
`ifdef CHECKSUM_EN
        exp_sum = 32'd10;
`else
        exp_sum = 32'd0;
`endif
        #2;
        check_reset_outputs("reset");
        tick; tick;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) poke(14'(i), 32'(i + 1));
        tick;
        // Basic copy, no stalls.
        go(14'd0, 14'd100, 14'd4);
        check("basic_first", {busy, m_read, m_write, m_byteenable}, {1'b1, 1'b1, 1'b0, 4'hF});
        check("basic_first_addr", m_address, 64'd0);
        wait_done(cyc);
        check("basic_cycles", cyc, 64'd12);
        check("basic_csum", checksum, exp_sum);
        tick;
        check("basic_after", {busy, done}, 64'd0);
        for (int i = 0; i < 4; i++) check("basic_mem", mem[100 + i], 64'(i + 1));
        // Same copy with two waitrequest cycles on every request.
        stall_en = 1'b1;
        tick;
        go(14'd0, 14'd200, 14'd4);
        wait_done(cyc);
        check("wait_cycles", cyc, 64'd28);
        check("wait_csum", checksum, exp_sum);
        tick;
        stall_en = 1'b0;
        for (int i = 0; i < 4; i++) check("wait_mem", mem[200 + i], 64'(i + 1));
        check("wait_stable", stab_bad, 64'd0);
        check("wait_stall_seen", stab_chk > 0, 64'd1);
        // Out-of-range start.
        b0 = bus_cnt; d0 = done_cnt;
        go(14'd10000, 14'd0, 14'd30);
        check("err_pulse", {error, busy}, {1'b1, 1'b0});
        tick;
        check("err_clear", {error, busy}, 64'd0);
        tick; tick;
        check("err_nobus", bus_cnt - b0, 64'd0);
        check("err_nodone", done_cnt - d0, 64'd0);
        // Boundary: dst+len exactly DEPTH is legal.
        go(14'd0, 14'd10023, 14'd1);
        check("edge_ok", {error, busy}, {1'b0, 1'b1});
        wait_done(cyc);
        check("edge_cycles", cyc, 64'd3);
        tick;
        check("edge_mem", mem[10023], 64'd1);
        // Zero-length copy.
        b0 = bus_cnt;
        go(14'd5, 14'd6, 14'd0);
        check("zero_busy_done", {busy, done, error}, {1'b1, 1'b1, 1'b0});
        check("zero_csum", checksum, 64'd0);
        tick;
        check("zero_after", {busy, done}, 64'd0);
        check("zero_nobus", bus_cnt - b0, 64'd0);
        // Reset during the write of word 2.
        go(14'd0, 14'd300, 14'd4);
        n = 0;
        while (!(m_write && m_address == 14'd301) && n < 50) begin
            tick;
            n++;
        end
        check("rst_reached_write", n < 50, 64'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        tick;
        reset = 1'b0;
        tick;
        go(14'd0, 14'd400, 14'd2);
        wait_done(cyc);
        check("rst_restart_cycles", cyc, 64'd6);
        tick;
        check("rst_restart_mem0", mem[400], 64'd1);
        check("rst_restart_mem1", mem[401], 64'd2);
        // Start during a copy is ignored.
        d0 = done_cnt;
        go(14'd0, 14'd500, 14'd3);
        tick;
        start = 1'b1; src_addr = 14'd2; dst_addr = 14'd600; len = 14'd1;
        tick;
        start = 1'b0;
        cyc = 2;
        while (!done && cyc < 200) begin
            tick;
            cyc++;
        end
        check("ign_cycles", cyc, 64'd9);
        for (int i = 0; i < 12; i++) tick;
        check("ign_done_once", done_cnt - d0, 64'd1);
        for (int i = 0; i < 3; i++) check("ign_mem", mem[500 + i], 64'(i + 1));
        check("never_both", both_bad, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
